// File: rtl/umi_merge.sv
// Narrow-to-wide UMI merger: coalesces contiguous data-carrying packets of up to IDW bits
// into single packets of up to ODW bits, with one merge buffer and a registered output.
module umi_merge #(
  parameter int unsigned CW      = 32,
  parameter int unsigned AW      = 64,
  parameter int unsigned IDW     = 64,
  parameter int unsigned ODW     = 256,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic           umi_clk,
  input  logic           umi_reset,
  input  logic           umi_in_valid,
  output logic           umi_in_ready,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_out_valid,
  input  logic           umi_out_ready,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data
);

  localparam int unsigned IB   = IDW / 8;
  localparam int unsigned OB   = ODW / 8;
  localparam int unsigned NW   = $clog2(OB) + 1;
  localparam int unsigned OFFW = $clog2(OB);
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  // UMI command field positions
  localparam int unsigned OpLsb   = 0;
  localparam int unsigned SizeLsb = 5;
  localparam int unsigned LenLsb  = 8;
  localparam int unsigned EomBit  = 22;

  localparam logic [4:0] OpReqWrite  = 5'h03;
  localparam logic [4:0] OpReqPosted = 5'h05;
  localparam logic [4:0] OpRespRead  = 5'h02;

  // Everything except len and eom must match for an append
  localparam logic [CW-1:0] CmdMask = ~(CW'(32'h0040_ff00));

  typedef enum logic [1:0] {StEmpty, StAccum, StFull} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]  buf_cmd_q;
  logic [AW-1:0]  buf_dst_q;
  logic [AW-1:0]  buf_src_q;
  logic [ODW-1:0] buf_data_q;
  logic [NW-1:0]  buf_n_q;
  logic [TW-1:0]  timer_q;

  // Input field decode
  logic [4:0]     in_op;
  logic [2:0]     in_size;
  logic [7:0]     in_len;
  logic           in_eom;
  logic [15:0]    in_bytes;
  logic           in_mergeable;
  logic [NW-1:0]  load_bytes;
  logic [IDW-1:0] in_data_masked;
  logic [ODW-1:0] in_wide;

  assign in_op        = umi_in_cmd[OpLsb +: 5];
  assign in_size      = umi_in_cmd[SizeLsb +: 3];
  assign in_len       = umi_in_cmd[LenLsb +: 8];
  assign in_eom       = umi_in_cmd[EomBit];
  assign in_bytes     = (16'(in_len) + 16'd1) << in_size;
  assign in_mergeable = (in_op == OpReqWrite) | (in_op == OpReqPosted) | (in_op == OpRespRead);

  // Non-data packets (e.g. read requests) may advertise more bytes than fit the input bus
  assign load_bytes = (in_bytes > 16'(IB)) ? NW'(IB) : in_bytes[NW-1:0];

  always_comb begin
    in_data_masked = '0;
    for (int i = 0; i < IB; i++) begin
      if (NW'(i) < load_bytes) begin
        in_data_masked[i*8 +: 8] = umi_in_data[i*8 +: 8];
      end
    end
  end

  assign in_wide = ODW'(in_data_masked);

  // Append and close conditions
  logic [OFFW-1:0] buf_off;
  logic            same_cmd;
  logic            fits;
  logic            can_append;
  logic [NW-1:0]   append_n;
  logic [7:0]      append_len;
  logic [OFFW-1:0] load_next_off;
  logic [OFFW-1:0] append_next_off;
  logic            load_close;
  logic            append_close;

  assign buf_off  = buf_dst_q[OFFW-1:0];
  assign same_cmd = ((umi_in_cmd ^ buf_cmd_q) & CmdMask) == '0;
  assign fits     = (17'(buf_off) + 17'(buf_n_q) + 17'(in_bytes)) <= 17'(OB);

  assign can_append = (state_q == StAccum) & ~buf_cmd_q[EomBit] & in_mergeable & same_cmd &
                      (umi_in_dstaddr == buf_dst_q + AW'(buf_n_q)) &
                      (umi_in_srcaddr == buf_src_q + AW'(buf_n_q)) & fits;

  assign append_n   = buf_n_q + in_bytes[NW-1:0];
  assign append_len = 8'(append_n >> buf_cmd_q[SizeLsb +: 3]) - 8'd1;

  assign load_next_off   = umi_in_dstaddr[OFFW-1:0] + load_bytes[OFFW-1:0];
  assign append_next_off = buf_dst_q[OFFW-1:0] + append_n[OFFW-1:0];

  assign load_close   = in_eom | ~in_mergeable | (load_bytes == NW'(OB)) |
                        (load_next_off == '0);
  assign append_close = in_eom | (append_n == NW'(OB)) | (append_next_off == '0);

  logic accept;
  logic do_load;
  logic do_append;

  assign accept    = umi_in_valid & umi_in_ready;
  assign do_load   = accept & (state_q == StEmpty);
  assign do_append = accept & (state_q == StAccum);

  // State register
  always_ff @(posedge umi_clk or posedge umi_reset) begin
    if (umi_reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an appendable input beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (umi_in_valid) begin
          state_d = load_close ? StFull : StAccum;
        end
      end
      StAccum: begin
        if (umi_in_valid) begin
          state_d = (can_append && !append_close) ? StAccum : StFull;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (umi_out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Handshake outputs
  always_comb begin
    umi_in_ready  = 1'b0;
    umi_out_valid = 1'b0;
    unique case (state_q)
      StEmpty: umi_in_ready  = ~umi_reset;
      StAccum: umi_in_ready  = ~umi_reset & umi_in_valid & can_append;
      StFull:  umi_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Merge buffer; buf_cmd_q always carries the rebuilt len/eom of the merged packet
  always_ff @(posedge umi_clk or posedge umi_reset) begin
    if (umi_reset) begin
      buf_cmd_q  <= '0;
      buf_dst_q  <= '0;
      buf_src_q  <= '0;
      buf_data_q <= '0;
      buf_n_q    <= '0;
      timer_q    <= '0;
    end else if (do_load) begin
      buf_cmd_q  <= umi_in_cmd;
      buf_dst_q  <= umi_in_dstaddr;
      buf_src_q  <= umi_in_srcaddr;
      buf_data_q <= in_wide;
      buf_n_q    <= load_bytes;
      timer_q    <= '0;
    end else if (do_append) begin
      buf_cmd_q[LenLsb +: 8] <= append_len;
      buf_cmd_q[EomBit]      <= in_eom;
      buf_data_q             <= buf_data_q | (in_wide << {buf_n_q, 3'b000});
      buf_n_q                <= append_n;
      timer_q                <= '0;
    end else if (state_q == StAccum) begin
      timer_q <= timer_q + 1'b1;
    end else if ((state_q == StFull) && umi_out_ready) begin
      buf_n_q <= '0;
      timer_q <= '0;
    end
  end

  assign umi_out_cmd     = buf_cmd_q;
  assign umi_out_dstaddr = buf_dst_q;
  assign umi_out_srcaddr = buf_src_q;
  assign umi_out_data    = buf_data_q;

endmodule
